// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for the adaptive-filter step-size scheduler.
package adaptive_filter_pkg;

  localparam int unsigned MU_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 24;

  // Power-on step size: 0.1 in unsigned Q0.32
  localparam logic [31:0] MU_RESET = 32'h199a_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2,
    ST_FINAL = 2'd3
  } mu_state_e;

endpackage : adaptive_filter_pkg

// File: rtl/adaptive_filter_mu_sched_if.sv
// Sample-stream events in, step size and scheduler status out.
interface adaptive_filter_mu_sched_if
  import adaptive_filter_pkg::*;
#(
  parameter int unsigned MU_W = MU_W_DEF
);

  logic            sample_tick;
  logic            sample_eob;
  logic            restart;
  logic [MU_W-1:0] mu_out;
  logic [1:0]      state_out;
  logic            converged;

  modport master (
    output sample_tick, sample_eob, restart,
    input  mu_out, state_out, converged
  );

  modport slave (
    input  sample_tick, sample_eob, restart,
    output mu_out, state_out, converged
  );

endinterface : adaptive_filter_mu_sched_if

// File: rtl/adaptive_filter_mu_sched.sv
// Step-size (mu) scheduler for an adaptive filter: hold mu at a start value
// for step_len samples, then decay it geometrically every step_len samples
// until it reaches the floor value.
// Optional feature macro: ADAPTIVE_FILTER_MU_SCHED_EOB_RESTART_EN
//   defined   -> last sample of a burst restarts the schedule
//   undefined -> burst boundaries are ignored
module adaptive_filter_mu_sched
  import adaptive_filter_pkg::*;
#(
  parameter int unsigned MU_W  = MU_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  axis_data_clk,
  input  logic                  axis_data_rst,
  input  logic                  cfg_enable,
  input  logic [MU_W-1:0]       cfg_mu_start,
  input  logic [MU_W-1:0]       cfg_mu_final,
  input  logic [CNT_W-1:0]      cfg_step_len,
  input  logic [3:0]            cfg_decay_shift,
  adaptive_filter_mu_sched_if.slave bus
);

  localparam logic [MU_W-1:0] MU_RST = MU_W'(MU_RESET);

  mu_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MU_W-1:0]  mu_q, mu_d;
  logic             conv_q, conv_d;
  logic [MU_W-1:0]  start_q, start_d;
  logic [MU_W-1:0]  final_q, final_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [3:0]       shift_q, shift_d;

  logic             eob_restart_c;
  logic             restart_c;
  logic             boundary_c;
  logic             load_c;
  logic [MU_W-1:0]  mu_dec_c;

  // End-of-burst restart source
`ifdef ADAPTIVE_FILTER_MU_SCHED_EOB_RESTART_EN
  assign eob_restart_c = bus.sample_tick & bus.sample_eob;
`else
  logic eob_unused;
  assign eob_unused    = bus.sample_eob;
  assign eob_restart_c = 1'b0;
`endif

  assign restart_c  = bus.restart | eob_restart_c;
  assign boundary_c = bus.sample_tick && (cnt_q == (step_q - CNT_W'(1)));
  // shift==0 subtracts mu from itself, giving 0 and forcing the floor clamp
  assign mu_dec_c   = mu_q - (mu_q >> shift_q);

  // Next-state, counter and step-size computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mu_d    = mu_q;
    conv_d  = conv_q;
    start_d = start_q;
    final_d = final_q;
    step_d  = step_q;
    shift_d = shift_q;
    load_c  = 1'b0;

    if (!cfg_enable) begin
      state_d = ST_IDLE;
      mu_d    = cfg_mu_final;
      cnt_d   = '0;
      conv_d  = 1'b0;
    end else if ((state_q == ST_IDLE) || restart_c) begin
      load_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (boundary_c) begin
            cnt_d = '0;
            if (start_q <= final_q) begin
              state_d = ST_FINAL;
              mu_d    = final_q;
              conv_d  = 1'b1;
            end else begin
              state_d = ST_DECAY;
            end
          end else if (bus.sample_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DECAY: begin
          if (boundary_c) begin
            cnt_d = '0;
            if (mu_dec_c <= final_q) begin
              state_d = ST_FINAL;
              mu_d    = final_q;
              conv_d  = 1'b1;
            end else begin
              mu_d = mu_dec_c;
            end
          end else if (bus.sample_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // HOLD entry: capture config, zero-length step treated as one sample
    if (load_c) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      conv_d  = 1'b0;
      mu_d    = cfg_mu_start;
      start_d = cfg_mu_start;
      final_d = cfg_mu_final;
      step_d  = (cfg_step_len == '0) ? CNT_W'(1) : cfg_step_len;
      shift_d = cfg_decay_shift;
    end
  end

  // State and output registers
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mu_q    <= MU_RST;
      conv_q  <= 1'b0;
      start_q <= '0;
      final_q <= '0;
      step_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mu_q    <= mu_d;
      conv_q  <= conv_d;
      start_q <= start_d;
      final_q <= final_d;
      step_q  <= step_d;
      shift_q <= shift_d;
    end
  end

  assign bus.mu_out    = mu_q;
  assign bus.state_out = state_q;
  assign bus.converged = conv_q;

endmodule : adaptive_filter_mu_sched

// File: tb/tb_adaptive_filter_mu_sched.sv
// Self-checking bench for adaptive_filter_mu_sched.
module tb_adaptive_filter_mu_sched;
  import adaptive_filter_pkg::*;

  localparam int unsigned MU_W  = 32;
  localparam int unsigned CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_enable = 1'b0;
  logic [MU_W-1:0]  cfg_mu_start = '0;
  logic [MU_W-1:0]  cfg_mu_final = '0;
  logic [CNT_W-1:0] cfg_step_len = '0;
  logic [3:0]       cfg_decay_shift = '0;

  adaptive_filter_mu_sched_if #(.MU_W(MU_W)) bus ();

  adaptive_filter_mu_sched #(.MU_W(MU_W), .CNT_W(CNT_W)) dut (
    .axis_data_clk   (clk),
    .axis_data_rst   (rst),
    .cfg_enable      (cfg_enable),
    .cfg_mu_start    (cfg_mu_start),
    .cfg_mu_final    (cfg_mu_final),
    .cfg_step_len    (cfg_step_len),
    .cfg_decay_shift (cfg_decay_shift),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        eob;
    logic        rs;
    logic        en;
    logic        rst;
    logic [31:0] start;
    bit          chk;
    logic [31:0] mu;
    logic [1:0]  st;
    logic        cv;
    string       name;
  } row_t;

  row_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic row_t mk(logic tick, logic eob, logic rs, logic en, logic r,
                              logic [31:0] start, bit chk, logic [31:0] mu,
                              logic [1:0] st, string name);
    row_t x;
    x.tick = tick; x.eob = eob; x.rs = rs; x.en = en; x.rst = r;
    x.start = start; x.chk = chk; x.mu = mu; x.st = st;
    x.cv = (st == 2'd3);
    x.name = name;
    return x;
  endfunction

  // Reference schedule: start 0x80000000, floor 0x10000000, shift 1, 4 samples/step
  function automatic logic [31:0] sched_mu(int k);
    if (k < 8)  return 32'h8000_0000;
    if (k < 12) return 32'h4000_0000;
    if (k < 16) return 32'h2000_0000;
    return 32'h1000_0000;
  endfunction

  function automatic logic [1:0] sched_st(int k);
    if (k < 4)  return 2'd1;
    if (k < 16) return 2'd2;
    return 2'd3;
  endfunction

  task automatic set_ref_cfg();
    cfg_mu_final    = 32'h1000_0000;
    cfg_step_len    = 24'd4;
    cfg_decay_shift = 4'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    set_ref_cfg();
    rows.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 1, 32'h199a_0000, 2'd0, "reset"));
    rows.push_back(mk(1, 0, 0, 0, 1, 32'h8000_0000, 1, 32'h199a_0000, 2'd0, "reset_hold"));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 0, '0, 2'd0, "release"));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, "idle_final"));
    rows.push_back(mk(1, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, "idle_tick"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  task automatic test_decay_schedule();
    row_t rows[$];
    row_t e;
    set_ref_cfg();
    rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, "enter_hold"));
    for (int k = 1; k <= 18; k++) begin
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(k), sched_st(k),
                        $sformatf("decay_tick%0d", k)));
      if (k == 9 || k == 17)
        rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(k), sched_st(k),
                          $sformatf("no_tick_after%0d", k)));
    end
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, "disable"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  task automatic test_start_below_final();
    row_t rows[$];
    row_t e;
    cfg_mu_final    = 32'h1000_0000;
    cfg_step_len    = 24'd2;
    cfg_decay_shift = 4'd1;
    rows.push_back(mk(0, 0, 0, 1, 0, 32'h0800_0000, 1, 32'h0800_0000, 2'd1, "low_enter"));
    rows.push_back(mk(1, 0, 0, 1, 0, 32'h0800_0000, 1, 32'h0800_0000, 2'd1, "low_tick1"));
    rows.push_back(mk(1, 0, 0, 1, 0, 32'h0800_0000, 1, 32'h1000_0000, 2'd3, "low_tick2"));
    rows.push_back(mk(1, 0, 0, 1, 0, 32'h0800_0000, 1, 32'h1000_0000, 2'd3, "low_final_held"));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h0800_0000, 1, 32'h1000_0000, 2'd0, "low_disable"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  // shift 0 with step length 1, then step length 0 which must act as 1
  task automatic test_shift_zero();
    row_t rows[$];
    row_t e;
    cfg_mu_final    = 32'h1000_0000;
    cfg_decay_shift = 4'd0;
    for (int s = 1; s >= 0; s--) begin
      rows.delete();
      cfg_step_len = CNT_W'(s);
      rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, $sformatf("sh0_len%0d_enter", s)));
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd2, $sformatf("sh0_len%0d_tick1", s)));
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd3, $sformatf("sh0_len%0d_tick2", s)));
      rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, $sformatf("sh0_len%0d_disable", s)));
      foreach (rows[i]) begin
        rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
        bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
        if (rows[i].chk) exp_q.push_back(rows[i]);
        @(posedge clk); #1;
        bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
        if (rows[i].chk) begin
          e = exp_q.pop_front();
          n_run++;
          if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
            n_fail++;
            $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                     e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
          end
        end
      end
    end
  endtask

  // Mid-run cfg change is ignored; restart wins over a decay boundary; disable wins over restart
  task automatic test_restart();
    row_t rows[$];
    row_t e;
    set_ref_cfg();
    rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, "rs_enter"));
    for (int k = 1; k <= 7; k++)
      rows.push_back(mk(1, 0, 0, 1, 0, (k >= 5) ? 32'h7000_0000 : 32'h8000_0000, 1,
                        sched_mu(k), sched_st(k), $sformatf("rs_tick%0d", k)));
    rows.push_back(mk(1, 0, 1, 1, 0, 32'h7000_0000, 1, 32'h7000_0000, 2'd1, "restart_on_boundary"));
    rows.push_back(mk(1, 0, 0, 1, 0, 32'h7000_0000, 1, 32'h7000_0000, 2'd1, "restart_hold_tick"));
    rows.push_back(mk(0, 0, 1, 1, 0, 32'h6000_0000, 1, 32'h6000_0000, 2'd1, "restart_no_tick"));
    rows.push_back(mk(0, 0, 1, 0, 0, 32'h6000_0000, 1, 32'h1000_0000, 2'd0, "disable_beats_restart"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  task automatic test_eob();
    row_t rows[$];
    row_t e;
    set_ref_cfg();
    rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, "eob_enter"));
    for (int k = 1; k <= 9; k++)
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(k), sched_st(k), $sformatf("eob_tick%0d", k)));
`ifdef ADAPTIVE_FILTER_MU_SCHED_EOB_RESTART_EN
    rows.push_back(mk(1, 1, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, "eob_restart"));
    for (int j = 1; j <= 6; j++)
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(j), sched_st(j), $sformatf("eob_after%0d", j)));
`else
    rows.push_back(mk(1, 1, 0, 1, 0, 32'h8000_0000, 1, sched_mu(10), sched_st(10), "eob_ignored"));
    for (int k = 11; k <= 16; k++)
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(k), sched_st(k), $sformatf("eob_tick%0d", k)));
`endif
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, "eob_disable"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  task automatic test_reset_mid_decay();
    row_t rows[$];
    row_t e;
    set_ref_cfg();
    rows.push_back(mk(0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 2'd1, "rmd_enter"));
    for (int k = 1; k <= 6; k++)
      rows.push_back(mk(1, 0, 0, 1, 0, 32'h8000_0000, 1, sched_mu(k), sched_st(k), $sformatf("rmd_tick%0d", k)));
    rows.push_back(mk(1, 0, 0, 1, 1, 32'h8000_0000, 1, 32'h199a_0000, 2'd0, "reset_in_decay"));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 0, '0, 2'd0, "rmd_release"));
    rows.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 1, 32'h1000_0000, 2'd0, "rmd_idle_final"));
    foreach (rows[i]) begin
      rst = rows[i].rst; cfg_enable = rows[i].en; cfg_mu_start = rows[i].start;
      bus.sample_tick = rows[i].tick; bus.sample_eob = rows[i].eob; bus.restart = rows[i].rs;
      if (rows[i].chk) exp_q.push_back(rows[i]);
      @(posedge clk); #1;
      bus.sample_tick = 1'b0; bus.sample_eob = 1'b0; bus.restart = 1'b0;
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        n_run++;
        if (bus.mu_out !== e.mu || bus.state_out !== e.st || bus.converged !== e.cv) begin
          n_fail++;
          $display("FAIL %s: got mu=%h st=%0d cv=%b, want mu=%h st=%0d cv=%b",
                   e.name, bus.mu_out, bus.state_out, bus.converged, e.mu, e.st, e.cv);
        end
      end
    end
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.sample_eob  = 1'b0;
    bus.restart     = 1'b0;
    test_reset();
    test_decay_schedule();
    test_start_below_final();
    test_shift_zero();
    test_restart();
    test_eob();
    test_reset_mid_decay();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_adaptive_filter_mu_sched

// File: doc/adaptive_filter_mu_sched.md
ADAPTIVE_FILTER_MU_SCHED -- requirements
Module: adaptive_filter_mu_sched

Interface
REQ-001 SHALL have parameter MU_W, default 32, step-size width (unsigned Q0.MU_W, 0x199a0000 = 0.1).
REQ-002 SHALL have parameter CNT_W, default 24, sample-counter width.
REQ-003 SHALL have port axis_data_clk, input, 1, the only clock.
REQ-004 SHALL have port axis_data_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_enable, input, 1, scheduler run enable.
REQ-006 SHALL have port cfg_mu_start, input, MU_W, initial step size.
REQ-007 SHALL have port cfg_mu_final, input, MU_W, floor step size.
REQ-008 SHALL have port cfg_step_len, input, CNT_W, samples per hold/decay step (0 treated as 1).
REQ-009 SHALL have port cfg_decay_shift, input, 4, decay rate: mu -= mu>>shift.
REQ-010 SHALL have port sample_tick, input, 1, one main-stream sample accepted (tvalid&tready).
REQ-011 SHALL have port sample_eob, input, 1, qualifies sample_tick as last sample of burst (teob&tlast).
REQ-012 SHALL have port restart, input, 1, single-cycle restart pulse.
REQ-013 SHALL have port mu_out, output, MU_W, step size driven to filter core mu input.
REQ-014 SHALL have port state_out, output, 2, current state (IDLE=0, HOLD=1, DECAY=2, FINAL=3).
REQ-015 SHALL have port converged, output, 1, high while in FINAL.

Function
REQ-016 SHALL implement states IDLE, HOLD, DECAY, FINAL; all outputs registered.
REQ-017 IDLE: mu_out = cfg_mu_final; on cfg_enable=1 -> HOLD, latch cfg_mu_start/final/step_len/shift, mu_out=latched start, counter=0.
REQ-018 HOLD: counter increments per sample_tick; on tick with counter==step_len-1 -> DECAY (counter=0), or -> FINAL with mu_out=final if start<=final.
REQ-019 DECAY: on tick with counter==step_len-1, mu_next = mu - (mu>>shift); if mu_next<=final then mu_out=final, -> FINAL, else mu_out=mu_next; counter=0.
REQ-020 shift==0 SHALL yield mu_next=0, hence clamp to final and FINAL at first decay boundary.
REQ-021 FINAL: mu_out held at latched final; converged=1; counter frozen.
REQ-022 mu_out SHALL change exactly one cycle after the qualifying sample_tick; no change without a tick.
REQ-023 restart=1 in any non-IDLE state SHALL re-latch config and enter HOLD with mu_out=start next cycle; restart beats a coincident step boundary.
REQ-024 cfg_enable=0 SHALL force IDLE next cycle from any state; beats restart.
REQ-025 cfg_* changes while not in IDLE SHALL have no effect until next HOLD entry.
REQ-026 Arithmetic SHALL be unsigned MU_W-bit, no wrap: mu_next never exceeds mu.

Reset
REQ-027 On axis_data_rst: state=IDLE, counter=0, mu_out=0x199a0000 (truncated/extended to MU_W), converged=0, latched config cleared.
REQ-028 Reset mid-run SHALL abandon the schedule; mu_out=cfg_mu_final from second cycle after reset release if cfg_enable=0.

Configuration
REQ-029 Macro ADAPTIVE_FILTER_MU_SCHED_EOB_RESTART_EN defined: sample_tick&sample_eob SHALL act as restart (after that sample's own update is discarded).
REQ-030 Macro undefined: sample_eob SHALL be ignored; schedule runs across bursts.

Structure
REQ-031 Shared package adaptive_filter_pkg SHALL hold state enum, MU_W/CNT_W defaults, MU_RESET constant 0x199a0000.
REQ-032 No sub-module; decay arithmetic and counter inline.

Verification
REQ-033 start=0x80000000, final=0x10000000, shift=1, step_len=4, continuous ticks -> DECAY after tick 4; mu 0x40000000 at tick 8, 0x20000000 at 12, 0x10000000 + FINAL at 16.
REQ-034 start=0x08000000, final=0x10000000, step_len=2 -> FINAL, mu_out=0x10000000 one cycle after tick 2.
REQ-035 shift=0, step_len=1 -> HOLD->DECAY on tick 1, FINAL with mu=final on tick 2.
REQ-036 restart coincident with DECAY boundary tick -> HOLD, mu_out=start, no decay applied.
REQ-037 EOB_RESTART_EN defined, sample_eob on tick 10 of REQ-033 case -> HOLD, mu_out=0x80000000; undefined -> schedule unaffected.
REQ-038 Reset asserted in DECAY -> mu_out=0x199a0000, state_out=0, converged=0 next cycle.
